kronos_idex_stage: RTL and testbench



---
 rtl/kronos_types.sv | 31 +++
 rtl/kronos_idex_stage_scoreboard.sv | 55 +++++
 rtl/kronos_idex_stage.sv | 141 ++++++++++++++
 tb/tb_kronos_idex_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_types.sv
// -----------------------------------------------------------------------------
// kronos_types
// Shared types and constants for the Kronos pipeline slice.
//   REG_ADDR_W : width of a register index (x0..x31)
//   REG_COUNT  : number of architectural integer registers
//   pipeIDEX_t : decoded instruction handed from ID to EX
//   ir_rd()    : destination-register field of a 32-bit instruction word
// -----------------------------------------------------------------------------
package kronos_types;

    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  aluop;
        logic        regwr_alu;
        logic        load;
        logic        store;
        logic        illegal;
    } pipeIDEX_t;

    // Destination register index lives in ir[11:7] for every format that has one
    function automatic logic [REG_ADDR_W-1:0] ir_rd(input logic [31:0] ir);
        return ir[11:7];
    endfunction

endpackage

// File: rtl/kronos_idex_stage_scoreboard.sv
// -----------------------------------------------------------------------------
// kronos_scoreboard
// Tracks register write-backs that EX has accepted but not yet retired.
// Ports:
//   clk, rstz        : clock, asynchronous active-low reset
//   set_en, set_sel  : mark register set_sel as having a write outstanding
//   clr_en, clr_sel  : write-back of register clr_sel has arrived
//   busy_mask        : registered scoreboard, bit n = write to xn outstanding
// A set and a clear on the same index in one cycle leave the bit set, since
// the set belongs to a younger instruction than the retiring write. x0 is
// hard-wired to never look busy.
// -----------------------------------------------------------------------------
module kronos_scoreboard
    import kronos_types::*;
(
    input  logic                  clk,
    input  logic                  rstz,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_sel,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_sel,
    output logic [REG_COUNT-1:0]  busy_mask
);

    logic [REG_COUNT-1:0] busy_r;
    logic [REG_COUNT-1:0] busy_next_s;

    // Next scoreboard value: apply the clear first so a same-index set overrides it
    always_comb begin
        busy_next_s = busy_r;
        if (clr_en) begin
            busy_next_s[clr_sel] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (set_en && (set_sel != 5'd0)) begin
            busy_next_s[set_sel] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
        busy_next_s[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    assign busy_mask = busy_r;

endmodule

// File: rtl/kronos_idex_stage.sv
// -----------------------------------------------------------------------------
// kronos_idex_stage
// ID/EX pipeline register with a source-register hazard interlock.
// Ports:
//   clk, rstz                 : clock, asynchronous active-low reset
//   dec_payload               : decoded instruction (rd = ir[11:7])
//   dec_rs1/dec_rs2           : source register indices
//   dec_rs1_used/dec_rs2_used : instruction actually reads that source
//   dec_rd_wr                 : instruction writes rd back to the register file
//   dec_vld/dec_rdy           : decoder handshake (dec_rdy is combinational)
//   decode/decode_vld         : held instruction presented to EX
//   decode_rdy                : EX accepts the held instruction
//   flush                     : EX redirect; drops the held entry
//   regwr_en/regwr_sel        : EX register write-back strobe and index
//   busy_mask                 : outstanding write-backs, bit 0 always 0
//   stall                     : decoder has an instruction it cannot hand over
// A single entry, no skid buffer. The scoreboard bit for a destination is set
// when EX accepts the instruction, never on capture, so instructions that are
// flushed or never accepted (e.g. excepting ones) cannot leave a stale bit.
// -----------------------------------------------------------------------------
module kronos_idex_stage
    import kronos_types::*;
#(
    parameter bit EN_INTERLOCK = 1'b1
)(
    input  logic                  clk,
    input  logic                  rstz,
    input  pipeIDEX_t             dec_payload,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_rs1_used,
    input  logic                  dec_rs2_used,
    input  logic                  dec_rd_wr,
    input  logic                  dec_vld,
    output logic                  dec_rdy,
    output pipeIDEX_t             decode,
    output logic                  decode_vld,
    input  logic                  decode_rdy,
    input  logic                  flush,
    input  logic                  regwr_en,
    input  logic [REG_ADDR_W-1:0] regwr_sel,
    output logic [REG_COUNT-1:0]  busy_mask,
    output logic                  stall
);

    pipeIDEX_t             decode_r;
    logic                  decode_vld_r;
    logic [REG_ADDR_W-1:0] held_rd_r;
    logic                  held_rd_wr_r;

    logic [REG_COUNT-1:0]  busy_mask_s;
    logic                  rs1_haz_s;
    logic                  rs2_haz_s;
    logic                  hazard_s;
    logic                  dec_rdy_s;
    logic                  capture_s;
    logic                  accept_s;
    logic                  sb_set_s;

    // Source hazards: a register is unsafe to read while its write is in the
    // scoreboard or while the held (not yet accepted) entry is about to write it.
    // The registered mask is used on purpose: a bit cleared this cycle still
    // stalls for one bubble because there is no write-to-read bypass in the RF.
    always_comb begin
        rs1_haz_s = 1'b0;
        rs2_haz_s = 1'b0;
        if (dec_rs1_used && (dec_rs1 != 5'd0)) begin
            rs1_haz_s = busy_mask_s[dec_rs1]
                     || (decode_vld_r && held_rd_wr_r && (held_rd_r == dec_rs1));
        end else begin
            rs1_haz_s = 1'b0;
        end
        if (dec_rs2_used && (dec_rs2 != 5'd0)) begin
            rs2_haz_s = busy_mask_s[dec_rs2]
                     || (decode_vld_r && held_rd_wr_r && (held_rd_r == dec_rs2));
        end else begin
            rs2_haz_s = 1'b0;
        end
    end

    // Interlock enable: forwarding builds still keep the scoreboard but never stall on it
    always_comb begin
        hazard_s = 1'b0;
        if (EN_INTERLOCK) begin
            hazard_s = rs1_haz_s || rs2_haz_s;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Handshake terms; flush blocks capture so a redirected stream is never latched
    always_comb begin
        dec_rdy_s = !flush && !hazard_s && (!decode_vld_r || decode_rdy);
        capture_s = dec_vld && dec_rdy_s;
        accept_s  = decode_vld_r && decode_rdy;
        sb_set_s  = accept_s && held_rd_wr_r && (held_rd_r != 5'd0);
    end

    // Entry valid flag and destination bookkeeping
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            decode_vld_r <= 1'b0;
            held_rd_r    <= 5'd0;
            held_rd_wr_r <= 1'b0;
        end else if (capture_s) begin
            decode_vld_r <= 1'b1;
            held_rd_r    <= ir_rd(dec_payload.ir);
            held_rd_wr_r <= dec_rd_wr;
        end else if (flush || accept_s) begin
            decode_vld_r <= 1'b0;
        end else begin
            decode_vld_r <= decode_vld_r;
        end
    end

    // Payload register: only meaningful while decode_vld is high, so not reset
    always_ff @(posedge clk) begin
        if (capture_s) begin
            decode_r <= dec_payload;
        end else begin
            decode_r <= decode_r;
        end
    end

    kronos_scoreboard u_scoreboard (
        .clk       (clk),
        .rstz      (rstz),
        .set_en    (sb_set_s),
        .set_sel   (held_rd_r),
        .clr_en    (regwr_en),
        .clr_sel   (regwr_sel),
        .busy_mask (busy_mask_s)
    );

    assign dec_rdy    = dec_rdy_s;
    assign decode     = decode_r;
    assign decode_vld = decode_vld_r;
    assign busy_mask  = busy_mask_s;
    assign stall      = dec_vld && !dec_rdy_s && !flush;

endmodule

// File: tb/tb_kronos_idex_stage.sv
// Self-checking bench for kronos_idex_stage: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_kronos_idex_stage;
    import kronos_types::*;

    localparam bit EN = 1'b1;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    pipeIDEX_t   dec_payload;
    logic [4:0]  dec_rs1 = 5'd0, dec_rs2 = 5'd0;
    logic        dec_rs1_used = 1'b0, dec_rs2_used = 1'b0, dec_rd_wr = 1'b0;
    logic        dec_vld = 1'b0;
    logic        dec_rdy;
    pipeIDEX_t   decode;
    logic        decode_vld;
    logic        decode_rdy = 1'b1;
    logic        flush = 1'b0;
    logic        regwr_en = 1'b0;
    logic [4:0]  regwr_sel = 5'd0;
    logic [31:0] busy_mask;
    logic        stall;

    int n_checks = 0;
    int n_err = 0;

    kronos_idex_stage #(.EN_INTERLOCK(EN)) dut (
        .clk(clk), .rstz(rstz), .dec_payload(dec_payload),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_rd_wr(dec_rd_wr), .dec_vld(dec_vld), .dec_rdy(dec_rdy),
        .decode(decode), .decode_vld(decode_vld), .decode_rdy(decode_rdy),
        .flush(flush), .regwr_en(regwr_en), .regwr_sel(regwr_sel),
        .busy_mask(busy_mask), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One slot (valid, payload, destination); a set of registers with writes in flight.
    bit        m_busy [32];
    bit        m_vld = 1'b0;
    bit        m_rdwr = 1'b0;
    logic [4:0] m_rd = 5'd0;
    pipeIDEX_t m_pay;
    logic      m_rdy, m_cap, m_acc;

    function automatic bit src_blocked(input bit used, input logic [4:0] s);
        if (!used || s == 5'd0) return 1'b0;
        if (m_busy[s]) return 1'b1;
        return m_vld && m_rdwr && (m_rd == s);
    endfunction

    always_comb begin
        m_rdy = !flush && !(EN && (src_blocked(dec_rs1_used, dec_rs1) || src_blocked(dec_rs2_used, dec_rs2)))
              && (!m_vld || decode_rdy);
        m_acc = m_vld && decode_rdy;
        m_cap = dec_vld && m_rdy;
    end

    always @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
            m_vld  <= 1'b0;
            m_rdwr <= 1'b0;
            m_rd   <= 5'd0;
        end else begin
            if (regwr_en) m_busy[regwr_sel] <= 1'b0;
            // later NBA wins: a set on the same index overrides the clear
            if (m_acc && m_rdwr && m_rd != 5'd0) m_busy[m_rd] <= 1'b1;
            if (m_cap) begin
                m_vld  <= 1'b1;
                m_pay  <= dec_payload;
                m_rd   <= dec_payload.ir[11:7];
                m_rdwr <= dec_rd_wr;
            end else if (flush || m_acc) begin
                m_vld <= 1'b0;
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        logic [31:0] eb;
        if (rstz) begin
            for (int i = 0; i < 32; i++) eb[i] = m_busy[i];
            chk("busy_mask", 64'(busy_mask), 64'(eb));
            chk("decode_vld", 64'(decode_vld), 64'(m_vld));
            chk("dec_rdy", 64'(dec_rdy), 64'(m_rdy));
            chk("stall", 64'(stall), 64'(dec_vld && !m_rdy && !flush));
            if (m_vld) chk("decode_payload_differs", 64'(decode != m_pay), 64'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] r_ir(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    task automatic drive(input bit vld, input logic [31:0] ir, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input bit rdwr, input bit drdy, input bit fl,
                         input bit wen, input logic [4:0] wsel);
        dec_payload.pc        = $urandom;
        dec_payload.ir        = ir;
        dec_payload.op1       = $urandom;
        dec_payload.op2       = $urandom;
        dec_payload.aluop     = 4'($urandom_range(0, 15));
        dec_payload.regwr_alu = rdwr;
        dec_payload.load      = 1'b0;
        dec_payload.store     = 1'b0;
        dec_payload.illegal   = 1'b0;
        dec_vld = vld; dec_rs1 = rs1; dec_rs2 = rs2;
        dec_rs1_used = u1; dec_rs2_used = u2; dec_rd_wr = rdwr;
        decode_rdy = drdy; flush = fl; regwr_en = wen; regwr_sel = wsel;
    endtask

    task automatic idle(input bit wen, input logic [4:0] wsel);
        drive(1'b0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, wen, wsel);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ir_a, ir_b, ir_lw;

    initial begin
        drive(1'b0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        // Reset state
        @(negedge clk);
        chk("reset_decode_vld", 64'(decode_vld), 64'd0);
        chk("reset_busy", 64'(busy_mask), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        tick();
        rstz = 1'b1;

        // Back-to-back independent ADDs
        ir_a = r_ir(5'd5, 5'd1, 5'd2);
        ir_b = r_ir(5'd6, 5'd1, 5'd2);
        drive(1'b1, ir_a, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        @(negedge clk); chk("b2b_rdy0", 64'(dec_rdy), 64'd1);
        tick();
        drive(1'b1, ir_b, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        chk("b2b_rdy1", 64'(dec_rdy), 64'd1);
        chk("b2b_vld1", 64'(decode_vld), 64'd1);
        chk("b2b_ir1", 64'(decode.ir), 64'(ir_a));
        tick();
        idle(1'b0, 5'd0);
        @(negedge clk);
        chk("b2b_vld2", 64'(decode_vld), 64'd1);
        chk("b2b_ir2", 64'(decode.ir), 64'(ir_b));
        chk("b2b_busy5", 64'(busy_mask), 64'h20);
        tick();
        idle(1'b1, 5'd5);
        @(negedge clk); chk("b2b_busy56", 64'(busy_mask), 64'h60);
        tick();
        idle(1'b1, 5'd6);
        tick();
        idle(1'b0, 5'd0);
        @(negedge clk); chk("b2b_clean", 64'(busy_mask), 64'd0);
        tick();

        // ADD x5 then dependent ADD x7,x5,x0
        ir_b = r_ir(5'd7, 5'd5, 5'd0);
        drive(1'b1, ir_a, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, ir_b, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        @(negedge clk); chk("dep_stall_held", 64'(stall), 64'd1);
        tick();
        @(negedge clk);
        chk("dep_stall_busy", 64'(stall), 64'd1);
        chk("dep_busy5", 64'(busy_mask), 64'h20);
        tick();
        regwr_en = 1'b1; regwr_sel = 5'd5;
        @(negedge clk); chk("dep_stall_wb_cycle", 64'(stall), 64'd1);
        tick();
        regwr_en = 1'b0;
        @(negedge clk);
        chk("dep_busy_cleared", 64'(busy_mask), 64'd0);
        chk("dep_released", 64'(dec_rdy), 64'd1);
        tick();
        idle(1'b0, 5'd0);
        @(negedge clk); chk("dep_captured", 64'(decode.ir), 64'(ir_b));
        tick();
        idle(1'b1, 5'd7);
        tick();

        // x0 destination and x0 source
        drive(1'b1, r_ir(5'd0, 5'd0, 5'd0), 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, r_ir(5'd4, 5'd0, 5'd0), 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        @(negedge clk); chk("x0_no_stall", 64'(stall), 64'd0);
        tick();
        idle(1'b0, 5'd0);
        @(negedge clk); chk("x0_busy", 64'(busy_mask), 64'd0);
        tick();
        idle(1'b1, 5'd4);
        tick();

        // Same-cycle clear and set of x3
        drive(1'b1, r_ir(5'd3, 5'd1, 5'd2), 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        idle(1'b1, 5'd3);
        tick();
        idle(1'b0, 5'd0);
        @(negedge clk); chk("set_over_clear", 64'(busy_mask), 64'h8);
        tick();
        idle(1'b1, 5'd3);
        tick();

        // JAL x1 accepted in its own flush cycle with a decoder instruction pending
        drive(1'b1, {20'd0, 5'd1, 7'b1101111}, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, r_ir(5'd8, 5'd2, 5'd3), 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
        @(negedge clk);
        chk("flush_rdy", 64'(dec_rdy), 64'd0);
        chk("flush_stall", 64'(stall), 64'd0);
        tick();
        idle(1'b0, 5'd0);
        @(negedge clk);
        chk("flush_vld", 64'(decode_vld), 64'd0);
        chk("flush_busy1", 64'(busy_mask), 64'h2);
        tick();

        // Load to x10 held by EX for 4 cycles, next instruction reads x10
        ir_lw = {12'd0, 5'd2, 3'b010, 5'd10, 7'b0000011};
        drive(1'b1, ir_lw, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, r_ir(5'd11, 5'd10, 5'd0), 5'd10, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_rdy", 64'(dec_rdy), 64'd0);
            chk("hold_ir", 64'(decode.ir), 64'(ir_lw));
            chk("hold_vld", 64'(decode_vld), 64'd1);
            chk("hold_busy", 64'(busy_mask), 64'h2);
            tick();
        end

        // Asynchronous reset in the middle of the stall
        @(negedge clk);
        #1 rstz = 1'b0;
        #1;
        chk("arst_vld", 64'(decode_vld), 64'd0);
        chk("arst_busy", 64'(busy_mask), 64'd0);
        chk("arst_rdy", 64'(dec_rdy), 64'd1);
        chk("arst_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1 rstz = 1'b1;
        idle(1'b0, 5'd0);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int busy_idx[$];
            bit wen;
            logic [4:0] wsel, rd;
            logic [31:0] ir;
            busy_idx = {};
            for (int i = 1; i < 32; i++) if (m_busy[i]) busy_idx.push_back(i);
            wen = 1'b0; wsel = 5'd0;
            if (busy_idx.size() > 0 && $urandom_range(0, 9) < 4) begin
                wen = 1'b1;
                wsel = 5'(busy_idx[$urandom_range(0, busy_idx.size() - 1)]);
            end else if ($urandom_range(0, 19) == 0) begin
                wen = 1'b1;
                wsel = 5'($urandom_range(0, 31));
            end
            rd = 5'($urandom_range(0, 7));
            ir = $urandom;
            ir[11:7] = rd;
            drive($urandom_range(0, 9) < 7, ir, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, wen, wsel);
            tick();
        end

        idle(1'b0, 5'd0);
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
